// File: rtl/conv2d_stream.sv
// Streaming K x K 2-D convolution with runtime-loaded weights/bias, two-stage MAC pipeline.
// Optional build macro CONV2D_RELU_EN clamps negative results to zero in the output stage.
module conv2d_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned K_SIZE     = 3,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned FRAC_BITS  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic                                  in_sof,
  input  logic signed [DATA_WIDTH-1:0]          in_data,
  input  logic                                  w_we,
  input  logic [$clog2(K_SIZE*K_SIZE+1)-1:0]    w_addr,
  input  logic signed [DATA_WIDTH-1:0]          w_data,
  output logic                                  out_valid,
  output logic signed [DATA_WIDTH-1:0]          out_data,
  output logic                                  out_eof
);

  localparam int unsigned KK      = K_SIZE * K_SIZE;
  localparam int unsigned AW      = $clog2(KK + 1);
  localparam int unsigned PW      = 2 * DATA_WIDTH;
  localparam int unsigned AccW    = 2 * DATA_WIDTH + $clog2(KK) + 1;
  localparam int unsigned CW      = $clog2(IMG_W);
  localparam int unsigned RW      = $clog2(IMG_H);
  localparam int unsigned LbDepth = (K_SIZE - 1) * IMG_W;

  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColMin  = CW'(K_SIZE - 1);
  localparam logic [RW-1:0] RowMin  = RW'(K_SIZE - 1);

  localparam logic signed [AccW-1:0] SatMax = AccW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [AccW-1:0] SatMin = ~SatMax;

  // Entry KK holds the bias.
  logic signed [DATA_WIDTH-1:0] coef_q [KK+1];
  // Single shift chain; tap (j+1)*IMG_W-1 is the pixel j+1 rows above the incoming one.
  logic signed [DATA_WIDTH-1:0] lb_q   [LbDepth];
  logic signed [DATA_WIDTH-1:0] win_q  [K_SIZE][K_SIZE];
  logic [CW-1:0]                col_q, col_eff, col_d;
  logic [RW-1:0]                row_q, row_eff, row_d;
  logic                         win_hit, frame_end;
  logic                         win_valid_q, win_eof_q;
  logic signed [PW-1:0]         prod_q [KK];
  logic signed [AccW-1:0]       bias_q;
  logic                         s1_valid_q, s1_eof_q;
  logic signed [AccW-1:0]       acc, sh;
  logic signed [DATA_WIDTH-1:0] res;

  always_comb begin
    col_eff   = in_sof ? '0 : col_q;
    row_eff   = in_sof ? '0 : row_q;
    win_hit   = (col_eff >= ColMin) && (row_eff >= RowMin);
    frame_end = (col_eff == ColLast) && (row_eff == RowLast);
    col_d     = col_eff + 1'b1;
    row_d     = row_eff;
    if (col_eff == ColLast) begin
      col_d = '0;
      row_d = (row_eff == RowLast) ? '0 : row_eff + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_eof_q   <= 1'b0;
      for (int i = 0; i < int'(LbDepth); i++) lb_q[i] <= '0;
      for (int r = 0; r < int'(K_SIZE); r++)
        for (int c = 0; c < int'(K_SIZE); c++) win_q[r][c] <= '0;
    end else begin
      win_valid_q <= in_valid && win_hit;
      win_eof_q   <= in_valid && frame_end;
      if (in_valid) begin
        col_q   <= col_d;
        row_q   <= row_d;
        lb_q[0] <= in_data;
        for (int i = 1; i < int'(LbDepth); i++) lb_q[i] <= lb_q[i-1];
        for (int r = 0; r < int'(K_SIZE); r++)
          for (int c = 0; c < int'(K_SIZE) - 1; c++) win_q[r][c] <= win_q[r][c+1];
        for (int r = 0; r < int'(K_SIZE) - 1; r++)
          win_q[r][K_SIZE-1] <= lb_q[(int'(K_SIZE) - 1 - r) * int'(IMG_W) - 1];
        win_q[K_SIZE-1][K_SIZE-1] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(KK); i++) coef_q[i] <= '0;
    end else if (w_we && (w_addr <= AW'(KK))) begin
      coef_q[w_addr] <= w_data;
    end
  end

  // Stage 1: products sample the coefficients held before any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(KK); i++) prod_q[i] <= '0;
      bias_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_eof_q   <= 1'b0;
    end else begin
      for (int r = 0; r < int'(K_SIZE); r++)
        for (int c = 0; c < int'(K_SIZE); c++)
          prod_q[r*int'(K_SIZE)+c] <= win_q[r][c] * coef_q[r*int'(K_SIZE)+c];
      bias_q     <= AccW'(coef_q[KK]) <<< FRAC_BITS;
      s1_valid_q <= win_valid_q;
      s1_eof_q   <= win_eof_q;
    end
  end

  always_comb begin
    acc = bias_q;
    for (int i = 0; i < int'(KK); i++) acc = acc + AccW'(prod_q[i]);
    sh = acc >>> FRAC_BITS;
    if (sh > SatMax) begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sh < SatMin) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = sh[DATA_WIDTH-1:0];
    end
`ifdef CONV2D_RELU_EN
    if (res[DATA_WIDTH-1]) res = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= s1_valid_q;
      out_data  <= res;
      out_eof   <= s1_valid_q && s1_eof_q;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: two instances (FRAC_BITS 0 and 4) on a 5x5 frame, K=3,
// checked against a frame-array convolution model with per-beat latency tracking.
module tb_conv2d_stream;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int KK = K * K;
  localparam int AW = $clog2(KK + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, in_sof, w_we;
  logic signed [DW-1:0] in_data, w_data;
  logic [AW-1:0]        w_addr;
  logic                 out_valid_a, out_eof_a, out_valid_b, out_eof_b;
  logic signed [DW-1:0] out_data_a, out_data_b;

  always #5 clk = ~clk;

  conv2d_stream #(.DATA_WIDTH(DW), .K_SIZE(K), .IMG_W(W), .IMG_H(H), .FRAC_BITS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_eof(out_eof_a)
  );

  conv2d_stream #(.DATA_WIDTH(DW), .K_SIZE(K), .IMG_W(W), .IMG_H(H), .FRAC_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_eof(out_eof_b)
  );

  typedef struct {
    int     due;
    longint va;
    longint vb;
    bit     eof;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     pr = 0;
  int     pc = 0;
  longint img[H][W];
  longint wm[KK+1];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint finish_val(input longint s, input int frac);
    longint acc, r;
    acc = s + wm[KK] * (longint'(1) << frac);
    r = acc >>> frac;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef CONV2D_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic model_accept(input bit sof, input longint d);
    exp_t   e;
    longint s;
    if (sof) begin
      pr = 0;
      pc = 0;
    end
    img[pr][pc] = d;
    if (pr >= K - 1 && pc >= K - 1) begin
      s = 0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) s += img[pr-K+1+i][pc-K+1+j] * wm[i*K+j];
      e.due = cyc + 3;
      e.va  = finish_val(s, 0);
      e.vb  = finish_val(s, 4);
      e.eof = (pr == H - 1) && (pc == W - 1);
      q.push_back(e);
    end
    pc++;
    if (pc == W) begin
      pc = 0;
      pr++;
      if (pr == H) pr = 0;
    end
  endtask

  task automatic monitor();
    bit   ev;
    exp_t e;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("valid_a", 64'(out_valid_a), 64'(ev));
    chk("valid_b", 64'(out_valid_b), 64'(ev));
    if (ev) begin
      e = q.pop_front();
      chk("data_a", 64'(out_data_a), e.va);
      chk("data_b", 64'(out_data_b), e.vb);
      chk("eof_a", 64'(out_eof_a), 64'(e.eof));
      chk("eof_b", 64'(out_eof_b), 64'(e.eof));
    end else begin
      chk("eof_idle_a", 64'(out_eof_a), 0);
      chk("eof_idle_b", 64'(out_eof_b), 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic px(input bit v, input bit s, input longint d);
    in_valid = v;
    in_sof   = s;
    in_data  = d[DW-1:0];
    if (v) model_accept(s, d);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input longint d);
    w_we   = 1'b1;
    w_addr = AW'(a);
    w_data = d[DW-1:0];
    if (a <= KK) wm[a] = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic set_all(input longint wv, input longint bv);
    for (int i = 0; i < KK; i++) wr(i, wv);
    wr(KK, bv);
  endtask

  // mode 0: constant cval, 1: row*W+col, 2: random full range, 3: random small
  function automatic longint pix(input int mode, input int r, input int c, input longint cval);
    logic signed [DW-1:0] t;
    case (mode)
      0: return cval;
      1: return longint'(r * W + c);
      2: begin
        t = DW'($urandom);
        return longint'(t);
      end
      default: return longint'($urandom_range(200, 0)) - 100;
    endcase
  endfunction

  task automatic send_pixels(input int n, input int mode, input bit sof, input bit gaps,
                             input longint cval);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) px(0, 0, 0);
      end
      px(1, sof && (i == 0), pix(mode, i / W, i % W, cval));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    w_we     = 1'b0;
    rst_n    = 1'b0;
    q.delete();
    pr = 0;
    pc = 0;
    for (int i = 0; i <= KK; i++) wm[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    in_data = '0;
    w_data  = '0;
    w_addr  = '0;
    do_reset();
    chk("rst_valid_a", 64'(out_valid_a), 0);
    chk("rst_data_a", 64'(out_data_a), 0);
    chk("rst_eof_a", 64'(out_eof_a), 0);
    chk("rst_valid_b", 64'(out_valid_b), 0);
    chk("rst_data_b", 64'(out_data_b), 0);
    chk("rst_eof_b", 64'(out_eof_b), 0);

    // All ones: nine results of 9, eof on the last
    set_all(1, 0);
    send_pixels(W * H, 0, 1, 0, 1);
    idle(4);

    // Identity kernel
    set_all(0, 0);
    wr(4, 1);
    send_pixels(W * H, 1, 1, 0, 0);
    idle(4);

    // Saturation both ways
    set_all(100, 0);
    send_pixels(W * H, 0, 1, 0, 100);
    idle(4);
    set_all(-100, 0);
    send_pixels(W * H, 0, 1, 0, 100);
    idle(4);

    // Bias with fractional scaling (instance b expects 10)
    set_all(1, 1);
    send_pixels(W * H, 0, 1, 0, 16);
    idle(4);

    // Out-of-range addresses must leave the bias alone
    set_all(0, 0);
    wr(4, 1);
    wr(KK + 1, 777);
    wr((1 << AW) - 1, -5);
    send_pixels(W * H, 1, 1, 1, 0);
    idle(4);

    // Reset after 13 pixels; next frame starts at (0,0) without sof, weights cleared
    send_pixels(13, 1, 1, 0, 0);
    do_reset();
    send_pixels(W * H, 1, 0, 0, 0);
    idle(4);

    // sof mid-frame restarts at (0,0)
    set_all(0, 0);
    wr(4, 1);
    send_pixels(7, 1, 0, 0, 0);
    send_pixels(W * H, 1, 1, 0, 0);
    idle(4);

    // Negative weights: -9, or 0 with the clamp enabled
    set_all(-1, 0);
    send_pixels(W * H, 0, 1, 0, 1);
    idle(4);

    // Randomised weights, bias, pixels, gaps and partial frames
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < KK; i++) wr(i, longint'($urandom_range(1023, 0)) - 512);
      wr(KK, longint'($urandom_range(65535, 0)) - 32768);
      if (it % 2 == 1) send_pixels(int'($urandom_range(W * H - 1, 1)), 3, 1, 1, 0);
      send_pixels(W * H, (it < 3) ? 3 : 2, 1, 1, 0);
      send_pixels(W * H, 3, 0, 1, 0);
      idle(4);
    end

    idle(5);
    chk("drain", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
